return_address_stack: RTL

- Hardware call/return stack directly upstream of the program counter.
- On a subroutine call (jump2sub) it captures the PC's next-sequential address (npc) and pushes it.
- It presents the top entry combinationally as rl, so a retFsub in the same cycle loads the correct return address into rp; the pop then takes effect at the clock edge.
- Supports nested subroutines up to DEPTH levels and reports overflow/underflow for debug.

---
 rtl/return_address_stack.sv | 133 +++++++++++++
 1 files changed

// File: rtl/return_address_stack.sv
// Return-address stack feeding the program counter.
// A call pushes the next-sequential PC. The top entry is presented
// combinationally from state on rl, so a return can load it in the same
// cycle that the pop is requested. Storage is a circular buffer, so a push
// onto a full stack overwrites the oldest entry. Overflow and underflow are
// sticky debug flags.
module return_address_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 10,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          jump2sub,
    input  logic          retFsub,
    input  logic [AW-1:0] npc,
    output logic [AW-1:0] rl,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          udf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] tp_q, tp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic [PW-1:0] tp_plus_s;
    logic [PW-1:0] tp_minus_s;
    logic          empty_s;
    logic          full_s;

    // Status decode and wrapping neighbour pointers of the current top.
    always_comb begin
        tp_plus_s  = tp_q + PW'(1);
        tp_minus_s = tp_q - PW'(1);
        empty_s    = (count_q == {CW{1'b0}});
        full_s     = (count_q == CW'(DEPTH));
    end

    // Next-state selection: start clears; otherwise push/pop/replace.
    always_comb begin
        mem_d   = mem_q;
        tp_d    = tp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (start) begin
            // Entries are left in place; count=0 already hides them from rl.
            tp_d    = {PW{1'b0}};
            count_d = {CW{1'b0}};
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            case ({jump2sub, retFsub})
                2'b10: begin
                    // Push; when full the slot above the top is the oldest entry.
                    tp_d             = tp_plus_s;
                    mem_d[tp_plus_s] = npc;
                    if (full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                2'b01: begin
                    if (empty_s) begin
                        udf_d = 1'b1;
                    end else begin
                        tp_d    = tp_minus_s;
                        count_d = count_q - CW'(1);
                    end
                end
                2'b11: begin
                    if (empty_s) begin
                        // Nothing to return from: flag it and keep the call.
                        udf_d            = 1'b1;
                        tp_d             = tp_plus_s;
                        mem_d[tp_plus_s] = npc;
                        count_d          = CW'(1);
                    end else begin
                        // Return-then-call collapses to replacing the top.
                        mem_d[tp_q] = npc;
                    end
                end
                default: begin
                    mem_d = mem_q;
                end
            endcase
        end
    end

    // State registers with asynchronous clear, including the storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {AW{1'b0}};
            end
            tp_q    <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            tp_q    <= tp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Outputs come from state only; rl reads zero while the stack is empty.
    always_comb begin
        if (empty_s) begin
            rl = {AW{1'b0}};
        end else begin
            rl = mem_q[tp_q];
        end
        empty = empty_s;
        full  = full_s;
        count = count_q;
        ovf   = ovf_q;
        udf   = udf_q;
    end

endmodule
